// File: rtl/z_run_recorder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | z_run_recorder: measures runs of z high (saturating) and queues lengths  |
// | in a FIFO drained over valid/ready. Z_RUN_TIMESTAMP_EN adds start stamps.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module z_run_recorder #(
    parameter int CNT_W = 8,
    parameter int DEPTH = 4,
    parameter int TS_W  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   z,
    input  logic                   clear,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CNT_W-1:0]       out_len,
`ifdef Z_RUN_TIMESTAMP_EN
    output logic [TS_W-1:0]        out_ts,
`endif
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TS_W < 1) begin : g_param_check
        $error("z_run_recorder: DEPTH must be a power of two >= 2 and TS_W >= 1");
    end

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic               w_wr_en;
    logic               w_drop;
    logic               r_ovf;
    logic [c_ptr_w:0]   r_wptr;
    logic [c_ptr_w:0]   r_rptr;
    logic [c_ptr_w:0]   w_level;
    logic [CNT_W-1:0]   r_len_mem [DEPTH];

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_push      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (z) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = CNT_W'(1);
                end
            end
            S_RUN: begin
                if (z) begin
                    if (r_cnt != c_cnt_max) begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end else begin
                    w_push      = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Extra pointer bit: occupancy can only reach DEPTH, so its MSB alone marks full.
    assign w_level = r_wptr - r_rptr;
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = w_level[c_ptr_w];
    assign w_pop   = !w_empty && out_ready;
    assign w_wr_en = w_push && (!w_full || w_pop);
    assign w_drop  = w_push && w_full && !w_pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_wr_en) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (clear) begin
                r_ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_len_mem[r_wptr[c_ptr_w-1:0]] <= r_cnt;
        end
    end

    assign out_valid = !w_empty;
    assign out_len   = w_empty ? '0 : r_len_mem[r_rptr[c_ptr_w-1:0]];
    assign level     = w_level;
    assign overflow  = r_ovf;

`ifdef Z_RUN_TIMESTAMP_EN
    logic [TS_W-1:0] r_ts;
    logic [TS_W-1:0] r_ts_start;
    logic [TS_W-1:0] r_ts_mem [DEPTH];

    // Stamp taken on the edge that samples the first z=1 of a run.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ts       <= '0;
            r_ts_start <= '0;
        end else begin
            r_ts <= r_ts + 1'b1;
            if (r_state == S_IDLE && z) begin
                r_ts_start <= r_ts;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_ts_mem[r_wptr[c_ptr_w-1:0]] <= r_ts_start;
        end
    end

    assign out_ts = w_empty ? '0 : r_ts_mem[r_rptr[c_ptr_w-1:0]];
`endif

endmodule
`default_nettype wire

// File: tb/tb_z_run_recorder.sv
`default_nettype none
// Testbench for z_run_recorder: randomized and directed stimulus against a
// queue-based reference model, compared by an independent negedge monitor.
module tb_z_run_recorder;

    localparam int CNT_W = 8;
    localparam int DEPTH = 4;
    localparam int TS_W  = 16;
    localparam int LEN_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic z = 1'b0;
    logic clear = 1'b0;
    logic out_ready = 1'b0;
    logic out_valid;
    logic overflow;
    logic [CNT_W-1:0] out_len;
    logic [$clog2(DEPTH):0] level;
`ifdef Z_RUN_TIMESTAMP_EN
    logic [TS_W-1:0] out_ts;
`endif

    z_run_recorder #(.CNT_W(CNT_W), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .z         (z),
        .clear     (clear),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_len   (out_len),
`ifdef Z_RUN_TIMESTAMP_EN
        .out_ts    (out_ts),
`endif
        .level     (level),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int len;
        int ts;
    } entry_t;

    entry_t exp_q[$];
    int     checks = 0;
    int     errors = 0;
    bit     run_act;
    int     run_len;
    int     run_ts;
    int     edge_cnt;
    bit     exp_ovf;
    int     last_pop_len = -1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a run is counted in edges, its recorded length is the
    // count clipped to the maximum, and a completed run enters the queue if room.
    always @(posedge clk or posedge reset) begin
        bit drop;
        drop = 1'b0;
        if (reset) begin
            exp_q.delete();
            run_act  = 1'b0;
            run_len  = 0;
            run_ts   = 0;
            edge_cnt = 0;
            exp_ovf  = 1'b0;
        end else begin
            if (z) begin
                if (!run_act) begin
                    run_act = 1'b1;
                    run_len = 0;
                    run_ts  = edge_cnt % (1 << TS_W);
                end
                run_len++;
            end else if (run_act) begin
                entry_t e;
                run_act = 1'b0;
                e.len = (run_len > LEN_MAX) ? LEN_MAX : run_len;
                e.ts  = run_ts;
                if (exp_q.size() < DEPTH) exp_q.push_back(e);
                else drop = 1'b1;
            end
            if (drop) exp_ovf = 1'b1;
            else if (clear) exp_ovf = 1'b0;
            edge_cnt++;
        end
    end

    // Monitor: compares DUT against the queue head, consumes the head on handshake.
    always @(negedge clk) begin
        int el;
        el = exp_q.size();
        check("out_valid", int'(out_valid), (el != 0) ? 1 : 0);
        check("level", int'(level), el);
        check("overflow", int'(overflow), int'(exp_ovf));
        check("out_len", int'(out_len), (el != 0) ? exp_q[0].len : 0);
`ifdef Z_RUN_TIMESTAMP_EN
        check("out_ts", int'(out_ts), (el != 0) ? exp_q[0].ts : 0);
`endif
        if (el != 0 && out_ready && !reset) begin
            last_pop_len = int'(out_len);
            void'(exp_q.pop_front());
        end
    end

    task automatic drive(input bit zv, input bit rv, input bit cv);
        @(posedge clk);
        #2;
        z         = zv;
        out_ready = rv;
        clear     = cv;
    endtask

    task automatic do_reset(input bit z_after);
        @(posedge clk);
        #2;
        reset = 1'b1;
        z = 1'b0; out_ready = 1'b0; clear = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b0;
        z = z_after;
    endtask

    task automatic run(input int n, input bit rdy_at_end);
        repeat (n) drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, rdy_at_end, 1'b0);
    endtask

    task automatic drain;
        repeat (DEPTH + 1) drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int rp;
        bit zv;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        check("reset_valid", int'(out_valid), 0);
        check("reset_level", int'(level), 0);
        check("reset_ovf", int'(overflow), 0);

        // Run interrupted by reset leaves nothing behind
        repeat (3) drive(1'b1, 1'b0, 1'b0);
        do_reset(1'b0);
        repeat (2) drive(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("midrun_level", int'(level), 0);
        check("midrun_valid", int'(out_valid), 0);

        // Single run of 5
        run(5, 1'b0);
        @(posedge clk); @(negedge clk);
        check("single_valid", int'(out_valid), 1);
        check("single_len", int'(out_len), 5);
        check("single_level", int'(level), 1);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("single_popped_valid", int'(out_valid), 0);
        check("single_popped_len", int'(out_len), 0);

        // Saturation
        run(300, 1'b0);
        @(posedge clk); @(negedge clk);
        check("sat_len", int'(out_len), 255);
        drain();

        // Overflow with runs 1..5
        for (int l = 1; l <= 5; l++) run(l, 1'b0);
        @(posedge clk); @(negedge clk);
        check("ovf_level", int'(level), 4);
        check("ovf_flag", int'(overflow), 1);
        check("ovf_head", int'(out_len), 1);
        drain();
        check("ovf_last_drained", last_pop_len, 4);
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("clear_ovf", int'(overflow), 0);

        // Full FIFO: push and pop on the same edge
        for (int l = 1; l <= 4; l++) run(l, 1'b0);
        run(7, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("fullpp_level", int'(level), 4);
        check("fullpp_ovf", int'(overflow), 0);
        drain();
        check("fullpp_last", last_pop_len, 7);

`ifdef Z_RUN_TIMESTAMP_EN
        do_reset(1'b0);
        repeat (9) drive(1'b0, 1'b0, 1'b0);
        run(1, 1'b0);
        @(posedge clk); @(negedge clk);
        check("ts_at10", int'(out_ts), 10);
        drain();
        do_reset(1'b1);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        @(posedge clk); @(negedge clk);
        check("ts_gap_level", int'(level), 2);
        check("ts_gap_head", int'(out_ts), 0);
        drain();
`endif

        // Randomized traffic with varying consumer throughput
        rp = 50;
        zv = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (i % 64 == 0) rp = $urandom_range(0, 100);
            if ($urandom_range(0, 599) == 0) begin
                do_reset(1'b0);
                zv = 1'b0;
            end else begin
                zv = zv ? ($urandom_range(0, 99) < 70) : ($urandom_range(0, 99) < 45);
                drive(zv, $urandom_range(0, 99) < rp, $urandom_range(0, 99) < 3);
            end
        end
        drive(1'b0, 1'b0, 1'b0);
        drain();
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/z_run_recorder.md
# z_run_recorder

Downstream consumer of the `z` flag produced by the sequence-detecting FSM. It measures each contiguous run of `z` high in clock cycles, saturating the count, and queues completed run lengths in a small FIFO. Software or a downstream block drains the FIFO over a valid/ready interface. It sits directly after the detector and shares its clock.

## Interface
Parameters:
- `CNT_W`, 8: run-length width; lengths saturate at 2^CNT_W−1.
- `DEPTH`, 4: FIFO entries; must be a power of two, ≥2.
- `TS_W`, 16: timestamp width; used only when `Z_RUN_TIMESTAMP_EN` is defined.

Ports:
- `clk`, in, 1: clock; all state updates on the rising edge.
- `reset`, in, 1: asynchronous, active-high; clears all state immediately.
- `z`, in, 1: detector output, synchronous to `clk`.
- `clear`, in, 1: synchronous; clears `overflow`.
- `out_valid`, out, 1: FIFO head entry is valid.
- `out_ready`, in, 1: consumer accepts the head entry.
- `out_len`, out, CNT_W: run length of the head entry; 0 when the FIFO is empty.
- `out_ts`, out, TS_W: start timestamp of the head entry; present only with the macro; 0 when empty.
- `level`, out, clog2(DEPTH)+1: FIFO occupancy, 0..DEPTH.
- `overflow`, out, 1: sticky; set when a completed run is dropped.

## Operation
- Reset values: `out_valid`=0, `out_len`=0, `out_ts`=0, `level`=0, `overflow`=0. The FSM is in IDLE, the run counter is 0, the FIFO pointers are 0, and the timestamp counter is 0.
- Run FSM, two states:
  - IDLE: `z`=1 → RUN with counter=1. `z`=0 → stay in IDLE.
  - RUN: `z`=1 → counter+1, saturating at 2^CNT_W−1, and stay in RUN. `z`=0 → push the counter value and go to IDLE.
- Push: writes {len, ts} at the write pointer if `level`<DEPTH. If the FIFO is full and no pop occurs on that edge, the entry is dropped and `overflow`←1.
- Pop: `out_valid`&&`out_ready` on an edge advances the read pointer. `out_ready` while `out_valid`=0 has no effect.
- Simultaneous push and pop:
  - When full: the pop frees a slot, the push is accepted, `level` stays at DEPTH, and no overflow occurs.
  - When not empty and not full: both happen and `level` is unchanged.
  - When empty: no pop occurs (`out_valid`=0) and the push is accepted.
- `clear` and a dropping push on the same edge: `overflow` ends at 1 (set wins).
- Pointers wrap modulo DEPTH. Occupancy uses an extra pointer bit, so full and empty are distinguished.
- A run still in progress at reset is discarded and nothing is pushed.
- `out_len` and `out_ts` are driven from the head entry and held until it is popped. They are forced to 0 when empty.

## Timing
- `z` is sampled on each rising edge. N consecutive edges with `z`=1 followed by an edge with `z`=0 yield len=N, pushed on that `z`=0 edge.
- `out_valid` rises immediately after the push edge (1-cycle latency from `z` sampled low). There is no combinational path from `z` to any output.
- The head entry changes after the popping edge. Back-to-back pops give 1 entry/cycle.
- Minimum gap: a run ending and a new run starting on alternating edges, `z`=1,0,1,0, gives one push per two cycles. Every run is recorded.
- `reset` asserted at any time forces outputs to their reset values without waiting for a clock edge.

## Configuration
- `Z_RUN_TIMESTAMP_EN` defined:
  - A free-running TS_W counter increments every cycle and wraps at 2^TS_W.
  - Each entry stores the counter value at the edge where the run's first `z`=1 was sampled.
  - The `out_ts` port exists.
- Undefined: no timestamp counter, no storage for timestamps, and no `out_ts` port. All other behaviour is identical.

## Test plan
- Reset mid-run: raise `z` for 3 cycles, pulse `reset`, drop `z` → `out_valid`=0, `level`=0, nothing recorded.
- Single run: `z`=1 for 5 edges then 0, `out_ready`=0 → `out_valid`=1 the cycle after the falling sample, `out_len`=5, `level`=1. Assert `out_ready` for one cycle → `out_valid`=0, `out_len`=0.
- Saturation: CNT_W=8, `z`=1 for 300 edges → `out_len`=255.
- Overflow: DEPTH=4, `out_ready`=0, runs of lengths 1,2,3,4,5 → `level`=4, `overflow`=1, entries drain as 1,2,3,4. Then `clear` → `overflow`=0.
- Full with simultaneous push and pop: fill 4 entries, then end a run of length 7 on the same edge as a pop → `level` stays 4, `overflow`=0, and the last drained entry is 7.
- With `Z_RUN_TIMESTAMP_EN`: reset, `z` rises at cycle 10 → `out_ts`=10. Runs at 0 and 2 with `z`=1,0,1,0 give two entries with `out_len`=1,1 and `out_ts`=0,2.
